// File: rtl/shift_register_pkg.sv
// shift_register_pkg: operation and sequencer state encodings shared by the shift register unit
package shift_register_pkg;

    typedef enum logic [2:0] {
        OP_CLEAR = 3'd0,
        OP_LOAD  = 3'd1,
        OP_HOLD  = 3'd2,
        OP_SHL   = 3'd3,
        OP_SHR   = 3'd4,
        OP_ASR   = 3'd5,
        OP_ROL   = 3'd6,
        OP_ROR   = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFTING = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

endpackage

// File: rtl/shift_register_unit_shift_step.sv
// shift_step: one combinational step of a register operation, shared by single-cycle and sequenced paths
module shift_step
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_t              i_op,
    input  logic [WIDTH-1:0] i_value,
    input  logic [WIDTH-1:0] i_load,
    input  logic             i_fill,
    input  logic             i_carry,
    output logic [WIDTH-1:0] o_next,
    output logic             o_carry
);

    // next value and carry; LOAD and HOLD keep the previous carry
    always_comb begin
        o_next  = i_value;
        o_carry = i_carry;
        case (i_op)
            OP_CLEAR: begin
                o_next  = '0;
                o_carry = 1'b0;
            end
            OP_LOAD: o_next = i_load;
            OP_SHL: begin
                o_next  = {i_value[WIDTH-2:0], i_fill};
                o_carry = i_value[WIDTH-1];
            end
            OP_SHR: begin
                o_next  = {i_fill, i_value[WIDTH-1:1]};
                o_carry = i_value[0];
            end
            OP_ASR: begin
                o_next  = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
                o_carry = i_value[0];
            end
            OP_ROL: begin
                o_next  = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
                o_carry = i_value[WIDTH-1];
            end
            OP_ROR: begin
                o_next  = {i_value[0], i_value[WIDTH-1:1]};
                o_carry = i_value[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_register_unit.sv
// shift_register_unit: WIDTH-bit shift/rotate register with a multi-cycle shift-by-N sequencer
module shift_register_unit
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       operation,
    input  logic [WIDTH-1:0] in,
    input  logic             serial_in,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    op_t              r_op;
    logic             r_fill;
    logic [AMT_W-1:0] r_count;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;

    logic             w_seq_start;
    op_t              w_op;
    logic             w_fill;
    logic [WIDTH-1:0] w_next;
    logic             w_carry;

    // only shift/rotate codes (3..7) may start a sequence; the rest run as single-cycle ops
    assign w_seq_start = (r_state == ST_IDLE) && start && (operation >= 3'd3);
    assign w_op        = (r_state == ST_SHIFTING) ? r_op : op_t'(operation);
    assign w_fill      = (r_state == ST_SHIFTING) ? r_fill : serial_in;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .i_op    (w_op),
        .i_value (r_out),
        .i_load  (in),
        .i_fill  (w_fill),
        .i_carry (r_carry),
        .o_next  (w_next),
        .o_carry (w_carry)
    );

    // register update and sequencer: latch op/fill/count on start, step once per cycle while shifting
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_CLEAR;
            r_fill  <= 1'b0;
            r_count <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_seq_start) begin
                        r_op    <= op_t'(operation);
                        r_fill  <= serial_in;
                        r_count <= amount;
                        r_state <= (amount == '0) ? ST_DONE : ST_SHIFTING;
                    end else begin
                        r_out   <= w_next;
                        r_carry <= w_carry;
                    end
                end
                ST_SHIFTING: begin
                    r_out   <= w_next;
                    r_carry <= w_carry;
                    r_count <= r_count - 1'b1;
                    if (r_count == AMT_W'(1)) r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out   = r_out;
    assign carry = r_carry;
    assign zero  = (r_out == '0);
    assign busy  = (r_state == ST_SHIFTING);
    assign done  = (r_state == ST_DONE);

endmodule
